// File: rtl/buffer_read_serializer.sv
// Consumer end of the PE circular buffer: pops R_PARAM-word groups and serializes
// them one word per cycle onto a valid/ready stream, flagging the last word of a job.
module buffer_read_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int R_PARAM    = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          start,
    input  logic [CNT_WIDTH-1:0]          total_words,
    input  logic                          buf_valid,
    input  logic [DATA_WIDTH*R_PARAM-1:0] buf_data,
    output logic                          buf_read_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
);
    localparam int LANE_W = (R_PARAM > 1) ? $clog2(R_PARAM) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(R_PARAM - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                    state;
    logic [DATA_WIDTH*R_PARAM-1:0] group_q;
    logic [LANE_W-1:0]             lane_cnt;
    logic [CNT_WIDTH-1:0]          remaining;
    logic                          handshake;
    logic                          last_word;

    assign last_word   = (remaining == CNT_WIDTH'(1));
    // A flush cycle must neither pop the buffer nor consume a word.
    assign buf_read_en = (state == S_FETCH) && buf_valid && !flush;
    assign out_valid   = (state == S_SHIFT);
    assign handshake   = out_valid && out_ready && !flush;
    assign out_data    = out_valid ? group_q[int'(lane_cnt)*DATA_WIDTH +: DATA_WIDTH]
                                   : '0;
    assign out_last    = out_valid && last_word;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            group_q   <= '0;
            lane_cnt  <= '0;
            remaining <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            lane_cnt  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= total_words;
                        state     <= (total_words == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (buf_read_en) begin
                        group_q  <= buf_data;
                        lane_cnt <= '0;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (handshake) begin
                        remaining <= remaining - CNT_WIDTH'(1);
                        // Unused lanes of the final group are simply abandoned.
                        if (last_word) begin
                            lane_cnt <= '0;
                            state    <= S_DONE;
                        end else if (lane_cnt == LAST_LANE) begin
                            lane_cnt <= '0;
                            state    <= S_FETCH;
                        end else begin
                            lane_cnt <= lane_cnt + LANE_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_read_serializer.sv
// Self-checking bench for buffer_read_serializer: table-driven jobs, random jobs
// against a word-stream model of the buffer, and hand-written flush/reset sequences.
module tb_buffer_read_serializer;
    localparam int DW    = 8;
    localparam int R     = 4;
    localparam int CW    = 8;
    localparam int MEMSZ = 4096;

    logic          clk = 1'b0;
    logic          rst, flush, start, buf_valid, out_ready;
    logic [CW-1:0] total_words;
    logic [DW*R-1:0] buf_data;
    logic          buf_read_en, out_valid, out_last, busy, done;
    logic [DW-1:0] out_data;

    always #5 clk = ~clk;

    buffer_read_serializer #(.DATA_WIDTH(DW), .R_PARAM(R), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .total_words(total_words),
        .buf_valid(buf_valid), .buf_data(buf_data), .buf_read_en(buf_read_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    // Buffer model: an endless word stream; each pop consumes R consecutive words.
    logic [DW-1:0] mem [MEMSZ];
    int rd_ptr;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int total;
        int rdy_pct;
        int vld_pct;
        int stall_word;
        int stall_len;
        int gap_pop;
        int gap_len;
        int restart_c;
        int exp_pops;
        int exp_first_vld;
        int exp_done_c;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_buf();
        for (int l = 0; l < R; l++) buf_data[l*DW +: DW] = mem[(rd_ptr + l) % MEMSZ];
    endtask

    // Advance to 1 time unit after the next rising edge, retiring a pop seen this cycle.
    task automatic next_cycle();
        logic popped;
        popped = buf_read_en;
        @(posedge clk);
        #1;
        if (popped) rd_ptr = (rd_ptr + R) % MEMSZ;
        drive_buf();
    endtask

    task automatic run_job(input vec_t v);
        int base, pops, words, first_vld, done_c, stalled, gapped;
        next_cycle();
        base = rd_ptr; pops = 0; words = 0; first_vld = -1; done_c = -1;
        stalled = 0; gapped = 0;
        flush = 1'b0;
        for (int c = 0; c < 800; c++) begin
            start = (c == 0) || (c == v.restart_c);
            total_words = (c == 0) ? CW'(v.total) : CW'(200);
            #1;
            buf_valid = (int'($urandom_range(99)) < v.vld_pct);
            out_ready = (int'($urandom_range(99)) < v.rdy_pct);
            if (busy && !out_valid && !done && pops == v.gap_pop && gapped < v.gap_len) begin
                buf_valid = 1'b0;
                gapped++;
            end
            if (out_valid && words == v.stall_word && stalled < v.stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end
            #1;
            if (!buf_valid && busy && !out_valid && !done)
                check("gap_no_pop", int'(buf_read_en), 0);
            if (out_valid && !out_ready) begin
                check("stall_data", int'(out_data), int'(mem[(base + words) % MEMSZ]));
                check("stall_no_pop", int'(buf_read_en), 0);
            end
            if (buf_read_en) pops++;
            if (out_valid && first_vld < 0) first_vld = c;
            if (out_valid && out_ready) begin
                check("word_data", int'(out_data), int'(mem[(base + words) % MEMSZ]));
                check("word_last", int'(out_last), int'(words == v.total - 1));
                words++;
            end
            if (done) done_c = c;
            next_cycle();
            if (done_c >= 0) break;
        end
        start = 1'b0;
        check("job_pops", pops, v.exp_pops);
        check("job_words", words, v.total);
        if (v.exp_first_vld >= 0) check("job_first_valid", first_vld, v.exp_first_vld);
        else if (v.total == 0) check("job_no_valid", first_vld, -1);
        if (v.exp_done_c >= 0) check("job_done_cycle", done_c, v.exp_done_c);
        else check("job_done_seen", int'(done_c >= 0), 1);
        #2;
        check("post_busy", int'(busy), 0);
        check("post_done", int'(done), 0);
    endtask

    initial begin
        vec_t rv;
        int base;
        //            total rdy vld  stW stL gapP gapL rst pops fv  done
        vecs[0]  = '{   8, 100, 100, -1, 0, -1, 0, -1,  2,  2,  11};
        vecs[1]  = '{   6, 100, 100, -1, 0, -1, 0, -1,  2,  2,   9};
        vecs[2]  = '{   0, 100, 100, -1, 0, -1, 0, -1,  0, -1,   1};
        vecs[3]  = '{   1, 100, 100, -1, 0, -1, 0, -1,  1,  2,   3};
        vecs[4]  = '{   4, 100, 100, -1, 0, -1, 0, -1,  1,  2,   6};
        vecs[5]  = '{   5, 100, 100, -1, 0, -1, 0, -1,  2,  2,   8};
        vecs[6]  = '{   8, 100, 100,  1, 3, -1, 0, -1,  2,  2,  14};
        vecs[7]  = '{   8, 100, 100, -1, 0,  1, 5, -1,  2,  2,  16};
        vecs[8]  = '{   8, 100, 100, -1, 0,  0, 5, -1,  2,  7,  16};
        vecs[9]  = '{   4, 100, 100, -1, 0, -1, 0,  3,  1,  2,   6};
        vecs[10] = '{ 255, 100, 100, -1, 0, -1, 0, -1, 64,  2, 320};
        vecs[11] = '{  13,  50,  60, -1, 0, -1, 0, -1,  4, -1,  -1};

        for (int i = 0; i < MEMSZ; i++) mem[i] = DW'($urandom);
        rd_ptr = 0;
        rst = 1'b0; flush = 1'b0; start = 1'b0; buf_valid = 1'b0; out_ready = 1'b0;
        total_words = '0;
        drive_buf();
        #1 rst = 1'b1;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_read_en", int'(buf_read_en), 0);
        check("rst_done", int'(done), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_data", int'(out_data), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;

        for (int i = 0; i < 12; i++) run_job(vecs[i]);

        for (int i = 0; i < 25; i++) begin
            rv = '{0, 0, 0, -1, 0, -1, 0, -1, 0, -1, -1};
            rv.total    = int'($urandom_range(40));
            rv.rdy_pct  = 30 + int'($urandom_range(70));
            rv.vld_pct  = 30 + int'($urandom_range(70));
            rv.exp_pops = (rv.total + R - 1) / R;
            run_job(rv);
        end

        // Flush in the middle of SHIFT: back to IDLE, no done, only one group popped.
        next_cycle();
        base = rd_ptr;
        buf_valid = 1'b1; out_ready = 1'b1; total_words = CW'(8); start = 1'b1; #2;
        next_cycle(); start = 1'b0; #2;
        next_cycle(); #2;
        next_cycle(); flush = 1'b1; #2;
        check("flush_valid_before", int'(out_valid), 1);
        check("flush_no_pop", int'(buf_read_en), 0);
        next_cycle(); flush = 1'b0; #2;
        check("flush_busy", int'(busy), 0);
        check("flush_out_valid", int'(out_valid), 0);
        for (int k = 0; k < 3; k++) begin
            check("flush_no_done", int'(done), 0);
            next_cycle(); #2;
        end
        check("flush_one_pop", rd_ptr, (base + R) % MEMSZ);

        // flush and start together in IDLE: flush wins.
        next_cycle(); start = 1'b1; flush = 1'b1; total_words = CW'(5); #2;
        check("flush_start_no_pop", int'(buf_read_en), 0);
        next_cycle(); start = 1'b0; flush = 1'b0; #2;
        check("flush_beats_start", int'(busy), 0);

        // Asynchronous reset mid-job: outputs clear before the next edge.
        next_cycle();
        buf_valid = 1'b1; out_ready = 1'b1; total_words = CW'(8); start = 1'b1; #2;
        next_cycle(); start = 1'b0; #2;
        next_cycle(); #2;
        check("arst_pre_valid", int'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_out_data", int'(out_data), 0);
        check("arst_read_en", int'(buf_read_en), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive_buf();
        #2;

        // Normal jobs after abort: stream resumes at the next unpopped group.
        run_job(vecs[0]);
        run_job(vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
